mem_responder: RTL

Tagged main-memory responder: the memory-side end of the core's proc2mem/mem2proc bus. It accepts one command per cycle and acknowledges each accepted load with a 4-bit tag in the same cycle. The load data is returned LATENCY cycles later, together with that tag. The block serves as the memory model for core-level simulation and as the backing store behind the cache hierarchy.

---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/mem_rsp_pipe.sv | 27 ++
 rtl/mem_responder.sv | 87 ++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: bus command encodings, tag width and return-entry type
// shared by the memory responder and the core's memory interface.
package mem_responder_pkg;

    localparam int MEM_TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef struct packed {
        logic                 valid;
        logic [MEM_TAG_W-1:0] tag;
        logic [63:0]          data;
    } ret_entry_t;

endpackage

// File: rtl/mem_rsp_pipe.sv
// mem_rsp_pipe: LATENCY-deep delay line of load return entries,
// cleared by the asynchronous active-low reset.
module mem_rsp_pipe
    import mem_responder_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  ret_entry_t in_i,
    output ret_entry_t out_o
);

    ret_entry_t stage_q [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: tagged main-memory responder with fixed-latency load returns.
// Define MEM_RSP_STALL_EN to add the stall_i input that blocks acceptance.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 8192,
    parameter int LATENCY     = 4,
    parameter int NUM_TAGS    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef MEM_RSP_STALL_EN
    input  logic                 stall_i,
`endif
    input  logic [1:0]           proc2mem_command,
    input  logic [63:0]          proc2mem_addr,
    input  logic [63:0]          proc2mem_data,
    output logic [MEM_TAG_W-1:0] mem2proc_response,
    output logic [63:0]          mem2proc_data,
    output logic [MEM_TAG_W-1:0] mem2proc_tag
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [63:0]          mem_q [DEPTH_WORDS];
    logic [NUM_TAGS-1:0]  busy_q, busy_d;
    logic [MEM_TAG_W-1:0] free_tag;
    logic [AW-1:0]        word;
    logic                 stall, is_ld, is_st, accept;
    ret_entry_t           pipe_in, pipe_out;
    logic                 unused_addr;

`ifdef MEM_RSP_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    assign word        = proc2mem_addr[AW+2:3];
    assign unused_addr = ^{proc2mem_addr[63:AW+3], proc2mem_addr[2:0]};
    assign is_ld       = proc2mem_command == BUS_LOAD;
    assign is_st       = proc2mem_command == BUS_STORE;

    // Priority allocator: lowest-numbered free tag, 0 when the pool is exhausted.
    always_comb begin
        free_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--)
            if (!busy_q[i]) free_tag = MEM_TAG_W'(i + 1);
    end

    assign accept            = (is_ld || is_st) && free_tag != '0 && !stall;
    assign mem2proc_response = accept ? free_tag : '0;

    always_comb begin
        pipe_in = '0;
        if (accept && is_ld) pipe_in = '{valid: 1'b1, tag: free_tag, data: mem_q[word]};
    end

    // A returning tag and a newly allocated tag are never the same bit.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (pipe_out.valid && pipe_out.tag == MEM_TAG_W'(i + 1)) busy_d[i] = 1'b0;
            if (accept && is_ld && free_tag == MEM_TAG_W'(i + 1)) busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    always_ff @(posedge clk) begin
        if (accept && is_st) mem_q[word] <= proc2mem_data;
    end

    mem_rsp_pipe #(.LATENCY(LATENCY)) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .in_i  (pipe_in),
        .out_o (pipe_out)
    );

    assign mem2proc_tag  = pipe_out.tag;
    assign mem2proc_data = pipe_out.data;

endmodule
